// File: rtl/md_ctrl.sv
// md_ctrl : multiply/divide controller for the execute stage of the pipelined core.
//
// Accepts mult/multu/div/divu/mthi/mtlo commands, computes the result at the
// accept edge into pending registers, then holds busy for a fixed number of
// cycles before committing the result to the architectural HI/LO registers.
//
// Optional feature macro: MD_DIV0_GUARD_EN
//   defined     : div/divu with b==0 leave HI/LO unchanged at commit
//   not defined : div/divu with b==0 commit lo=0xFFFFFFFF, hi=a
//
// Parameters:
//   MULT_CYCLES : busy cycles for mult/multu (>=1)
//   DIV_CYCLES  : busy cycles for div/divu (>=1)
//
// Ports:
//   clk   in   core clock, rising edge
//   rst   in   synchronous reset, active-low
//   start in   command valid this cycle
//   op    in   3-bit command (1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo)
//   a     in   32-bit operand rs
//   b     in   32-bit operand rt
//   busy  out  operation in progress (registered)
//   hi    out  architectural HI register
//   lo    out  architectural LO register
module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic [31:0]        hi_q, lo_q;
   logic [31:0]        phi_q, plo_q;

   logic [31:0]        phi_d, plo_d;
   logic [CNT_W-1:0]   cnt_d;

   logic signed [63:0] smul;
   logic [63:0]        umul;
   logic               a_neg, b_neg;
   logic [31:0]        a_mag, b_mag, b_mag_safe, b_safe;
   logic [31:0]        mq, mr, sq, sr, uq, ur;

   assign smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign umul = {32'd0, a} * {32'd0, b};

   // Signed divide is done on magnitudes so that 0x80000000 / -1 falls out
   // naturally as 0x80000000 with remainder 0. Divisors of zero are replaced
   // by 1 so the datapath never sees an undefined divide; the result is
   // overridden below anyway.
   assign a_neg      = a[31];
   assign b_neg      = b[31];
   assign a_mag      = a_neg ? (~a + 32'd1) : a;
   assign b_mag      = b_neg ? (~b + 32'd1) : b;
   assign b_mag_safe = (b == 32'd0) ? 32'd1 : b_mag;
   assign b_safe     = (b == 32'd0) ? 32'd1 : b;
   assign mq         = a_mag / b_mag_safe;
   assign mr         = a_mag % b_mag_safe;
   assign sq         = (a_neg ^ b_neg) ? (~mq + 32'd1) : mq;
   assign sr         = a_neg ? (~mr + 32'd1) : mr;
   assign uq         = a / b_safe;
   assign ur         = a % b_safe;

   always_comb begin
      phi_d = hi_q;
      plo_d = lo_q;
      cnt_d = CNT_W'(DIV_CYCLES);
      case (op)
         OP_MULT: begin
            phi_d = smul[63:32];
            plo_d = smul[31:0];
            cnt_d = CNT_W'(MULT_CYCLES);
         end
         OP_MULTU: begin
            phi_d = umul[63:32];
            plo_d = umul[31:0];
            cnt_d = CNT_W'(MULT_CYCLES);
         end
         OP_DIV: begin
            phi_d = sr;
            plo_d = sq;
         end
         OP_DIVU: begin
            phi_d = ur;
            plo_d = uq;
         end
         default: ;
      endcase
      if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) begin
`ifdef MD_DIV0_GUARD_EN
         // HI/LO cannot change while busy, so capturing them now is the
         // same as leaving them untouched at commit.
         phi_d = hi_q;
         plo_d = lo_q;
`else
         phi_d = a;
         plo_d = 32'hFFFF_FFFF;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        phi_q   <= phi_d;
                        plo_q   <= plo_d;
                        cnt_q   <= cnt_d;
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                     end
                     OP_MTHI: hi_q <= a;
                     OP_MTLO: lo_q <= a;
                     default: ;
                  endcase
               end
            end
            S_BUSY: begin
               // Any start seen here is dropped; the hazard unit keeps md
               // instructions out of E while busy.
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  hi_q    <= phi_q;
                  lo_q    <= plo_q;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;

   // reference architectural state
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result of a multiply/divide from plain 64-bit arithmetic.
   task automatic ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl, output int n);
      logic [63:0]        p;
      logic signed [63:0] q, r;
      rh = m_hi; rl = m_lo; n = DC;
      case (o)
         3'd1: begin
            p = longint'($signed(x)) * longint'($signed(y));
            rh = p[63:32]; rl = p[31:0]; n = MC;
         end
         3'd2: begin
            p = {32'd0, x} * {32'd0, y};
            rh = p[63:32]; rl = p[31:0]; n = MC;
         end
         3'd3: begin
            if (y != 0) begin
               q = longint'($signed(x)) / longint'($signed(y));
               r = longint'($signed(x)) % longint'($signed(y));
               rl = q[31:0]; rh = r[31:0];
            end
         end
         3'd4: begin
            if (y != 0) begin
               rl = x / y; rh = x % y;
            end
         end
         default: ;
      endcase
      if ((o == 3'd3 || o == 3'd4) && y == 0) begin
`ifdef MD_DIV0_GUARD_EN
         rh = m_hi; rl = m_lo;
`else
         rh = x; rl = 32'hFFFF_FFFF;
`endif
      end
   endtask

   // Issue one command and follow it to completion. When inj is set, a
   // stray command (iop/ia) is presented during busy cycle 2.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit inj, input logic [2:0] iop, input logic [31:0] ia);
      logic [31:0] rh, rl;
      int n;
      ref_md(o, x, y, rh, rl, n);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      if (o == 3'd5 || o == 3'd6 || o == 3'd0 || o == 3'd7) begin
         if (o == 3'd5) m_hi = x;
         if (o == 3'd6) m_lo = x;
         chk("mv_busy", {31'd0, busy}, 32'd0);
         chk("mv_hi", hi, m_hi);
         chk("mv_lo", lo, m_lo);
         return;
      end
      for (int i = 0; i < n; i++) begin
         chk("win_busy", {31'd0, busy}, 32'd1);
         chk("win_hi_hold", hi, m_hi);
         chk("win_lo_hold", lo, m_lo);
         if (inj && i == 1) begin
            start = 1'b1; op = iop; a = ia; b = $urandom;
         end
         @(posedge clk); #1;
         start = 1'b0; op = 3'd0;
      end
      m_hi = rh; m_lo = rl;
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_hi", hi, m_hi);
      chk("done_lo", lo, m_lo);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0]  ro;
      logic [31:0] rx, ry;
      rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);

      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0, 32'd0);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFE);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0, 32'd0);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);
      run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'd0, 32'd0);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      run_op(3'd4, 32'd7, 32'd2, 1'b0, 3'd0, 32'd0);
      chk("divu_hi", hi, 32'd1);
      chk("divu_lo", lo, 32'd3);
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'd0, 32'd0);
      chk("ovf_hi", hi, 32'd0);
      chk("ovf_lo", lo, 32'h8000_0000);

      // divide by zero with preloaded HI/LO
      run_op(3'd5, 32'h11, 32'd0, 1'b0, 3'd0, 32'd0);
      run_op(3'd6, 32'h22, 32'd0, 1'b0, 3'd0, 32'd0);
      run_op(3'd3, 32'd5, 32'd0, 1'b0, 3'd0, 32'd0);
`ifdef MD_DIV0_GUARD_EN
      chk("div0_hi", hi, 32'h11);
      chk("div0_lo", lo, 32'h22);
`else
      chk("div0_hi", hi, 32'd5);
      chk("div0_lo", lo, 32'hFFFF_FFFF);
`endif

      // stray mtlo during busy is ignored
      run_op(3'd1, 32'd3, 32'd4, 1'b1, 3'd6, 32'h55);
      chk("inj_hi", hi, 32'd0);
      chk("inj_lo", lo, 32'd12);

      // reset in the middle of a divide
      start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      chk("rmid_busy1", {31'd0, busy}, 32'd1);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      m_hi = '0; m_lo = '0;
      for (int i = 0; i < DC + 2; i++) begin
         chk("rmid_busy", {31'd0, busy}, 32'd0);
         chk("rmid_hi", hi, 32'd0);
         chk("rmid_lo", lo, 32'd0);
         @(posedge clk); #1;
      end

      // reset wins over a simultaneous start
      run_op(3'd6, 32'h77, 32'd0, 1'b0, 3'd0, 32'd0);
      rst = 1'b0; start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd7;
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; op = 3'd0;
      m_hi = '0; m_lo = '0;
      chk("rprio_busy", {31'd0, busy}, 32'd0);
      chk("rprio_lo", lo, 32'd0);

      // back-to-back: second start issued in the first cycle busy is low
      run_op(3'd1, 32'd3, 32'd4, 1'b0, 3'd0, 32'd0);
      chk("b2b_lo1", lo, 32'd12);
      run_op(3'd1, 32'd5, 32'd6, 1'b0, 3'd0, 32'd0);
      chk("b2b_lo2", lo, 32'd30);

      // randomized commands against the reference model
      for (int k = 0; k < 80; k++) begin
         ro = 3'($urandom_range(0, 7));
         rx = pick();
         ry = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
         run_op(ro, rx, ry, ($urandom_range(0, 3) == 0), 3'($urandom_range(1, 6)), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
